// File: rtl/ariane_pkg.sv
// Core-wide types shared between the execute stage and the frontend.
//   cf_t             : control-flow classification of a resolved instruction.
//   bp_resolve_t     : branch resolution record from execute.
//   bht_prediction_t : {valid, taken} prediction served to fetch.
//   BHT_ENTRIES      : default branch history table depth.
package ariane_pkg;
  localparam int unsigned BHT_ENTRIES = 1024;

  typedef enum logic [2:0] {
    NoCF,
    Branch,
    Jump,
    JumpR,
    Return
  } cf_t;

  typedef struct packed {
    logic [riscv::VLEN-1:0] pc;
    logic [riscv::VLEN-1:0] target_address;
    logic                   valid;
    logic                   is_mispredict;
    logic                   is_taken;
    cf_t                    cf_type;
  } bp_resolve_t;

  typedef struct packed {
    logic valid;
    logic taken;
  } bht_prediction_t;
endpackage

// File: rtl/riscv.sv
// Minimal RISC-V architectural constants shared by the core.
// VLEN : virtual address width in bits.
package riscv;
  localparam int unsigned VLEN = 64;
endpackage

// File: rtl/bht_sat_counter.sv
// 2-bit saturating counter next-state function.
//   cnt_i   : current counter value.
//   taken_i : resolved direction (1 = taken).
//   cnt_o   : counter after training, clamped to [0, 3].
module bht_sat_counter (
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);
  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != 2'b11) cnt_o = cnt_i + 2'b01;
    end else begin
      if (cnt_i != 2'b00) cnt_o = cnt_i - 2'b01;
    end
  end
endmodule

// File: rtl/bht_sweep.sv
// Branch history table with a sequential clear sweep.
//   clk_i, rst_i        : clock, synchronous active-high reset.
//   flush_i             : discard all history and re-run the clear sweep.
//   debug_mode_i        : suppresses training while set.
//   lookup_valid_i/vpc_i: one prediction lookup per cycle.
//   bht_prediction_o    : {valid, taken}, one cycle after the lookup.
//   resolved_branch_i   : resolution record used for training.
//   init_done_o         : table is cleared and operational.
module bht_sweep
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = BHT_ENTRIES
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   debug_mode_i,
  input  logic                   lookup_valid_i,
  input  logic [riscv::VLEN-1:0] vpc_i,
  output bht_prediction_t        bht_prediction_o,
  input  bp_resolve_t            resolved_branch_i,
  output logic                   init_done_o
);
  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

  typedef struct packed {
    logic       valid;
    logic [1:0] cnt;
  } bht_entry_t;

  typedef enum logic {
    SWEEP,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
  logic             lookup_q, lookup_d;
  bht_entry_t       rd_q;
  bht_entry_t       bht_mem [NR_ENTRIES];

  logic             upd_en;
  logic [IDX_W-1:0] upd_idx, lkp_idx;
  bht_entry_t       upd_entry;
  logic [1:0]       cnt_next;

  // The single write port is shared between the clear sweep and training.
  logic             we;
  logic [IDX_W-1:0] waddr;
  bht_entry_t       wdata;

  // Half-word granular index; upper pc bits alias freely.
  assign upd_idx   = resolved_branch_i.pc[IDX_W:1];
  assign lkp_idx   = vpc_i[IDX_W:1];
  assign upd_entry = bht_mem[upd_idx];

  // Bits outside the index and the fields not needed for training.
  logic unused_bits;
  assign unused_bits = ^{vpc_i, resolved_branch_i};

  assign upd_en = resolved_branch_i.valid && (resolved_branch_i.cf_type == Branch) &&
                  !debug_mode_i && (state_q == RUN) && !flush_i;

  bht_sat_counter u_sat_counter (
    .cnt_i  (upd_entry.cnt),
    .taken_i(resolved_branch_i.is_taken),
    .cnt_o  (cnt_next)
  );

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    lookup_d    = 1'b0;
    we          = 1'b0;
    waddr       = sweep_idx_q;
    wdata       = '0;

    case (state_q)
      SWEEP: begin
        we          = 1'b1;
        sweep_idx_d = sweep_idx_q + 1'b1;
        if (sweep_idx_q == IDX_W'(NR_ENTRIES - 1)) state_d = RUN;
      end
      RUN: begin
        lookup_d = lookup_valid_i;
        if (upd_en) begin
          we    = 1'b1;
          waddr = upd_idx;
          // A fresh entry starts weakly biased toward the first outcome.
          if (upd_entry.valid) wdata = '{valid: 1'b1, cnt: cnt_next};
          else wdata = '{valid: 1'b1, cnt: (resolved_branch_i.is_taken ? 2'b10 : 2'b01)};
        end
      end
      default: state_d = SWEEP;
    endcase

    if (flush_i) begin
      state_d     = SWEEP;
      sweep_idx_d = '0;
      lookup_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= SWEEP;
      sweep_idx_q <= '0;
      lookup_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      lookup_q    <= lookup_d;
    end
  end

  // Storage: read and write in the same edge gives read-before-write.
  always_ff @(posedge clk_i) begin
    if (we && !rst_i) bht_mem[waddr] <= wdata;
    rd_q <= bht_mem[lkp_idx];
  end

  // rd_q is unreset storage data; lookup_q masks it so reset/flush give '0.
  assign bht_prediction_o.valid = lookup_q & rd_q.valid;
  assign bht_prediction_o.taken = lookup_q & rd_q.cnt[1];
  assign init_done_o            = (state_q == RUN);
endmodule
